wb_rr_arbiter: RTL

Parametrised N-master, single-slave Wishbone-style arbiter; successor to the fixed two-master ctrl/core arbiter in `risc_logic`. It grants the shared RAM bus to one master at a time using round-robin fairness, with a per-master priority override, and holds the grant until the slave acknowledges. It sits between `system_ctrl`/`core` (and future masters such as a DMA) and `ram`. An optional slave-timeout watchdog is also available.

---
 rtl/wb_arb_pkg.sv | 34 +++
 rtl/wb_rr_picker.sv | 38 +++
 rtl/wb_rr_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types, constants and helpers for wb_rr_arbiter (optional feature macro WB_ARB_TIMEOUT_EN)
`ifndef ADDR_SIZE
`define ADDR_SIZE 16
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Upper bound on master count handled by the index helper.
    localparam int MAX_MASTERS = 32;

    // Every bit of the read data returned on a watchdog timeout.
    localparam logic TIMEOUT_RDATA_BIT = 1'b1;

    // OR together the positions of set bits; exact for a one-hot input, 0 for all-zero.
    function automatic logic [4:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// rtl/wb_rr_picker.sv - combinational round-robin winner search starting just above the last winner
module wb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic                   found;
    int                     j;
    logic [IW-1:0]          j_idx;
    logic [MAX_MASTERS-1:0] gnt_ext;

    // Walk last+1, last+2, ... with wrap and take the first requester seen.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        j     = 0;
        j_idx = '0;
        for (int i = 1; i <= N; i++) begin
            j     = (int'(last) + i) % N;
            j_idx = IW'(j);
            if (!found && req[j_idx]) begin
                gnt[j_idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign gnt_ext = MAX_MASTERS'(gnt);
    assign idx     = IW'(onehot_to_idx(gnt_ext));

endmodule

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - N-master round-robin Wishbone arbiter with priority override; WB_ARB_TIMEOUT_EN adds a slave watchdog
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_W         = `ADDR_SIZE,
    parameter int DATA_W         = `WORD_SIZE,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic [N_MASTERS-1:0]        Prio_req,
    input  logic [N_MASTERS*ADDR_W-1:0] S_wb_addr,
    input  logic [N_MASTERS-1:0]        S_wb_cs,
    input  logic [N_MASTERS-1:0]        S_wb_we,
    input  logic [N_MASTERS*DATA_W-1:0] S_wb_wdata,
    output logic [N_MASTERS*DATA_W-1:0] S_wb_rdata,
    output logic [N_MASTERS-1:0]        S_wb_ack,
    output logic [ADDR_W-1:0]           M_wb_addr,
    output logic                        M_wb_cs,
    output logic                        M_wb_we,
    output logic [DATA_W-1:0]           M_wb_wdata,
    input  logic [DATA_W-1:0]           M_wb_rdata,
    input  logic                        M_wb_ack,
    output logic [N_MASTERS-1:0]        Grant,
    output logic                        Timeout_err
);

    localparam int IW = $clog2(N_MASTERS);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        last_q, last_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;

    logic [N_MASTERS-1:0] prio_cand;
    logic [N_MASTERS-1:0] cand;
    logic [N_MASTERS-1:0] win_gnt;
    logic [IW-1:0]        win_idx;
    logic                 busy;
    logic                 owner_cs;
    logic                 timeout_hit;

    assign busy      = (state_q == ARB_BUSY);
    assign owner_cs  = S_wb_cs[owner_q];
    assign prio_cand = S_wb_cs & Prio_req;
    assign cand      = (prio_cand != '0) ? prio_cand : S_wb_cs;

    wb_rr_picker #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_picker (
        .req  (cand),
        .last (last_q),
        .gnt  (win_gnt),
        .idx  (win_idx)
    );

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A same-cycle slave ack always beats the watchdog.
    assign timeout_hit = busy && !M_wb_ack && (cnt_q == CW'(TIMEOUT_CYCLES));

    // Count BUSY cycles without ack; held at zero while IDLE so each transfer starts fresh.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy) begin
            cnt_d = '0;
        end else if (!M_wb_ack && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign Timeout_err = timeout_hit;
    assign Grant       = grant_q;

    // Next-state: arbitrate only from IDLE; leave BUSY on ack, owner abort or timeout.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        if (!busy) begin
            if (S_wb_cs != '0) begin
                state_d = ARB_BUSY;
                owner_d = win_idx;
                last_d  = win_idx;
                grant_d = win_gnt;
            end
        end else if (M_wb_ack || !owner_cs || timeout_hit) begin
            state_d = ARB_IDLE;
            grant_d = '0;
        end
    end

    // Arbiter FSM and its registered grant/owner outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= IW'(N_MASTERS - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    // Bus steering: owner's signals pass straight through while BUSY, everything quiet in IDLE.
    always_comb begin
        M_wb_cs    = 1'b0;
        M_wb_we    = 1'b0;
        M_wb_addr  = '0;
        M_wb_wdata = '0;
        S_wb_ack   = '0;
        S_wb_rdata = '0;
        if (busy) begin
            M_wb_cs    = owner_cs;
            M_wb_we    = S_wb_we[owner_q];
            M_wb_addr  = S_wb_addr[owner_q*ADDR_W +: ADDR_W];
            M_wb_wdata = S_wb_wdata[owner_q*DATA_W +: DATA_W];
            S_wb_ack[owner_q] = M_wb_ack | timeout_hit;
            S_wb_rdata[owner_q*DATA_W +: DATA_W] =
                timeout_hit ? {DATA_W{TIMEOUT_RDATA_BIT}} : M_wb_rdata;
        end
    end

endmodule
